// File: rtl/fp_pkg.sv
// Shared constants and types for the IEEE-754 result encoder.
// Biases, half-precision special encodings, mode/class enums and the S1 beat record.
package fp_pkg;

    localparam int unsigned SP_EXP_BIAS = 127;
    localparam int unsigned HP_EXP_BIAS = 15;
    localparam int unsigned HP_REBIAS   = SP_EXP_BIAS - HP_EXP_BIAS;
    localparam int unsigned HP_EXP_MAX  = 31;

    localparam logic [15:0] HP_INF  = 16'h7C00;
    localparam logic [15:0] HP_QNAN = 16'h7E00;

    typedef enum logic {
        MODE_HALF   = 1'b0,
        MODE_SINGLE = 1'b1
    } fp_mode_e;

    // Input classes decided in S1 so S2 only needs the rounder for normal numbers
    typedef enum logic [2:0] {
        CL_ZERO,
        CL_TINY,
        CL_INF,
        CL_NAN,
        CL_NORM
    } fp_class_e;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

    typedef struct packed {
        fp_mode_e  mode;
        logic      sign;
        logic [7:0]  exp;
        logic [22:0] mant;
        fp_class_e cls;
        fp_flags_t flags;
    } s1_beat_t;

endpackage

// File: rtl/fp_encoder_if.sv
// Beat-level handshake bundle between the upstream producer, the encoder and the sink.
// master = producer/sink side, slave = encoder side.
interface fp_encoder_if;

    logic        in_valid;
    logic        in_ready;
    logic        mode_fp;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [22:0] in_mant;
    logic        in_overflow;
    logic        in_underflow;
    logic        in_inexact;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_inexact;

    modport master (
        output in_valid, mode_fp, in_sign, in_exp, in_mant,
               in_overflow, in_underflow, in_inexact, out_ready,
        input  in_ready, out_valid, out_word,
               out_overflow, out_underflow, out_inexact
    );

    modport slave (
        input  in_valid, mode_fp, in_sign, in_exp, in_mant,
               in_overflow, in_underflow, in_inexact, out_ready,
        output in_ready, out_valid, out_word,
               out_overflow, out_underflow, out_inexact
    );

endinterface

// File: rtl/fp_half_rounder.sv
// Combinational single-to-half magnitude rounder (round-to-nearest-even).
// Flags are local to the conversion; upstream flags are merged by the caller.
module fp_half_rounder
    import fp_pkg::*;
(
    input  logic signed [9:0] e_h_i,
    input  logic [22:0]       mant_i,
    output logic [14:0]       mag_o,
    output logic              overflow_o,
    output logic              underflow_o,
    output logic              inexact_o
);

    logic [9:0]  frac;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [14:0] norm_sum;
    logic [9:0]  neg_e;
    logic [5:0]  shamt;
    logic [33:0] sub_x;
    logic [10:0] sub_f;

    always_comb begin
        mag_o       = '0;
        overflow_o  = 1'b0;
        underflow_o = 1'b0;
        inexact_o   = 1'b0;
        frac        = '0;
        guard       = 1'b0;
        sticky      = 1'b0;
        round_up    = 1'b0;
        norm_sum    = '0;
        neg_e       = '0;
        shamt       = '0;
        sub_x       = '0;
        sub_f       = '0;

        if (e_h_i >= 10'sd31) begin
            mag_o      = HP_INF[14:0];
            overflow_o = 1'b1;
            inexact_o  = 1'b1;
        end else if (e_h_i >= 10'sd1) begin
            frac      = mant_i[22:13];
            guard     = mant_i[12];
            sticky    = |mant_i[11:0];
            round_up  = guard & (sticky | frac[0]);
            inexact_o = guard | sticky;
            // Carry out of the fraction naturally bumps the exponent field
            norm_sum  = {e_h_i[4:0], frac} + 15'(round_up);
            if (norm_sum[14:10] == 5'(HP_EXP_MAX)) begin
                mag_o      = HP_INF[14:0];
                overflow_o = 1'b1;
            end else begin
                mag_o = norm_sum;
            end
        end else begin
            // {1,mant} is pre-scaled by 2^10 so the fixed >>14 is folded in; shifts past 33 all collapse to sticky-only
            neg_e       = 10'(-e_h_i);
            shamt       = (neg_e > 10'd33) ? 6'd33 : neg_e[5:0];
            sub_x       = {1'b1, mant_i, 10'b0} >> shamt;
            guard       = sub_x[23];
            sticky      = |sub_x[22:0];
            round_up    = guard & (sticky | sub_x[24]);
            sub_f       = {1'b0, sub_x[33:24]} + 11'(round_up);
            mag_o       = {4'b0, sub_f};
            inexact_o   = guard | sticky;
            underflow_o = guard | sticky;
        end
    end

endmodule

// File: rtl/fp_encoder.sv
// Two-stage IEEE-754 packer: S1 registers and classifies the beat, S2 rounds/packs
// into output registers. Full valid/ready flow control, one beat per cycle sustained.
module fp_encoder
    import fp_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    fp_encoder_if.slave  bus
);

    s1_beat_t    s1_d, s1_q;
    logic        s1_valid_q;
    logic        out_valid_q;
    logic [31:0] out_word_d, out_word_q;
    fp_flags_t   out_flags_d, out_flags_q;
    logic        s2_adv;
    logic        in_ready;

    logic signed [9:0] e_h;
    logic [14:0]       rnd_mag;
    logic              rnd_ovf, rnd_unf, rnd_inx;

    assign s2_adv   = !out_valid_q || bus.out_ready;
    assign in_ready = !s1_valid_q || s2_adv;

    always_comb begin
        s1_d                 = '0;
        s1_d.mode            = fp_mode_e'(bus.mode_fp);
        s1_d.sign            = bus.in_sign;
        s1_d.exp             = bus.in_exp;
        s1_d.mant            = bus.in_mant;
        s1_d.flags.overflow  = bus.in_overflow;
        s1_d.flags.underflow = bus.in_underflow;
        s1_d.flags.inexact   = bus.in_inexact;
        if (bus.in_exp == 8'hFF) begin
            s1_d.cls = (bus.in_mant == '0) ? CL_INF : CL_NAN;
        end else if (bus.in_exp == 8'h00) begin
            s1_d.cls = (bus.in_mant == '0) ? CL_ZERO : CL_TINY;
        end else begin
            s1_d.cls = CL_NORM;
        end
    end

    assign e_h = signed'({2'b00, s1_q.exp} - 10'(HP_REBIAS));

    fp_half_rounder u_rounder (
        .e_h_i       (e_h),
        .mant_i      (s1_q.mant),
        .mag_o       (rnd_mag),
        .overflow_o  (rnd_ovf),
        .underflow_o (rnd_unf),
        .inexact_o   (rnd_inx)
    );

    always_comb begin
        out_word_d  = '0;
        out_flags_d = s1_q.flags;
        if (s1_q.mode == MODE_SINGLE) begin
            out_word_d = {s1_q.sign, s1_q.exp, s1_q.mant};
        end else begin
            case (s1_q.cls)
                CL_INF:  out_word_d[15:0] = {s1_q.sign, HP_INF[14:0]};
                CL_NAN:  out_word_d[15:0] = {s1_q.sign, HP_QNAN[14:0]};
                CL_ZERO: out_word_d[15:0] = {s1_q.sign, 15'b0};
                CL_TINY: begin
                    out_word_d[15:0]      = {s1_q.sign, 15'b0};
                    out_flags_d.underflow = 1'b1;
                    out_flags_d.inexact   = 1'b1;
                end
                default: begin
                    out_word_d[15:0]      = {s1_q.sign, rnd_mag};
                    out_flags_d.overflow  = s1_q.flags.overflow  | rnd_ovf;
                    out_flags_d.underflow = s1_q.flags.underflow | rnd_unf;
                    out_flags_d.inexact   = s1_q.flags.inexact   | rnd_inx;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_flags_q <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_q <= s1_d;
                end
            end
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_word_q  <= out_word_d;
                    out_flags_q <= out_flags_d;
                end
            end
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_word      = out_word_q;
    assign bus.out_overflow  = out_flags_q.overflow;
    assign bus.out_underflow = out_flags_q.underflow;
    assign bus.out_inexact   = out_flags_q.inexact;

endmodule

// File: tb/tb_fp_encoder.sv
// Scoreboard bench for fp_encoder: directed vectors push hand-computed results,
// an independent monitor pops and compares every output transfer.
module tb_fp_encoder;
    import fp_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_encoder_if bus ();

    fp_encoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] word;
        logic [2:0]  flags;
        int unsigned acc_cyc;
        bit          chk_lat;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    int unsigned n_out    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", nm, got, want);
        end
    endtask

    task automatic send(input string nm, input bit mode, input bit sgn, input logic [7:0] e,
                        input logic [22:0] m, input logic [2:0] fin,
                        input logic [31:0] wexp, input logic [2:0] fexp, input bit lat);
        exp_t x;
        bit   done;
        done = 1'b0;
        @(negedge clk);
        bus.in_valid     = 1'b1;
        bus.mode_fp      = mode;
        bus.in_sign      = sgn;
        bus.in_exp       = e;
        bus.in_mant      = m;
        {bus.in_overflow, bus.in_underflow, bus.in_inexact} = fin;
        #1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (bus.in_ready) begin
                @(posedge clk);
                x.name    = nm;
                x.word    = wexp;
                x.flags   = fexp;
                x.acc_cyc = cyc;
                x.chk_lat = lat;
                sb.push_back(x);
                done = 1'b1;
            end else begin
                @(negedge clk);
                #1;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_accept: actual=timeout required=accepted", nm);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        check_eq("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: compares transfers against the scoreboard and checks hold stability under backpressure
    initial begin
        logic [31:0] hw;
        logic [2:0]  hf;
        bit          held;
        exp_t        e;
        held = 1'b0;
        hw   = '0;
        hf   = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check_eq("hold_valid", 64'(bus.out_valid), 64'd1);
                    check_eq("hold_data",
                             64'({bus.out_word, bus.out_overflow, bus.out_underflow, bus.out_inexact}),
                             64'({hw, hf}));
                end
                held = 1'b0;
                if (bus.out_valid && !bus.out_ready) begin
                    held = 1'b1;
                    hw   = bus.out_word;
                    hf   = {bus.out_overflow, bus.out_underflow, bus.out_inexact};
                end
                if (bus.out_valid && bus.out_ready) begin
                    n_out++;
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat: actual=%h required=none", bus.out_word);
                    end else begin
                        e = sb.pop_front();
                        check_eq({e.name, "_word"}, 64'(bus.out_word), 64'(e.word));
                        check_eq({e.name, "_flags"},
                                 64'({bus.out_overflow, bus.out_underflow, bus.out_inexact}),
                                 64'(e.flags));
                        if (e.chk_lat) check_eq({e.name, "_latency"}, 64'(cyc - e.acc_cyc), 64'd2);
                    end
                end
            end
        end
    end

    initial begin
        int unsigned n_base;
        rst              = 1'b1;
        bus.in_valid     = 1'b0;
        bus.mode_fp      = 1'b0;
        bus.in_sign      = 1'b0;
        bus.in_exp       = '0;
        bus.in_mant      = '0;
        bus.in_overflow  = 1'b0;
        bus.in_underflow = 1'b0;
        bus.in_inexact   = 1'b0;
        bus.out_ready    = 1'b1;

        #3;
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_out_word", 64'(bus.out_word), 64'd0);
        check_eq("rst_flags", 64'({bus.out_overflow, bus.out_underflow, bus.out_inexact}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Back-to-back directed vectors, out_ready held high
        send("sp_one",      1, 0, 8'h7F, 23'h000000, 3'b000, 32'h3F800000, 3'b000, 1);
        send("sp_pass",     1, 1, 8'h80, 23'h123456, 3'b011, 32'hC0123456, 3'b011, 1);
        send("hp_1p5",      0, 0, 8'h7F, 23'h400000, 3'b000, 32'h00003E00, 3'b000, 1);
        send("hp_tie_even", 0, 0, 8'h7F, 23'h001000, 3'b000, 32'h00003C00, 3'b001, 1);
        send("hp_tie_odd",  0, 0, 8'h7F, 23'h003000, 3'b000, 32'h00003C02, 3'b001, 1);
        send("hp_ovf_exp",  0, 0, 8'h8F, 23'h000000, 3'b000, 32'h00007C00, 3'b101, 1);
        send("hp_ovf_rnd",  0, 0, 8'h8E, 23'h7FF000, 3'b000, 32'h00007C00, 3'b101, 1);
        send("hp_sub_half", 0, 0, 8'h70, 23'h000000, 3'b000, 32'h00000200, 3'b000, 1);
        send("hp_sub_min",  0, 0, 8'h67, 23'h000000, 3'b000, 32'h00000001, 3'b000, 1);
        send("hp_sub_zero", 0, 0, 8'h66, 23'h000000, 3'b000, 32'h00000000, 3'b011, 1);
        send("hp_ninf",     0, 1, 8'hFF, 23'h000000, 3'b100, 32'h0000FC00, 3'b100, 1);
        send("hp_nan",      0, 0, 8'hFF, 23'h000001, 3'b000, 32'h00007E00, 3'b000, 1);
        send("hp_nzero",    0, 1, 8'h00, 23'h000000, 3'b000, 32'h00008000, 3'b000, 1);
        send("hp_denorm",   0, 0, 8'h00, 23'h000005, 3'b000, 32'h00000000, 3'b011, 1);
        send("hp_sub_carry",0, 0, 8'h70, 23'h7FFFFF, 3'b000, 32'h00000400, 3'b011, 1);
        send("hp_sticky",   0, 1, 8'h80, 23'h002001, 3'b000, 32'h0000C001, 3'b001, 1);
        send("hp_big",      0, 0, 8'hFE, 23'h000000, 3'b000, 32'h00007C00, 3'b101, 1);
        send("hp_min_norm", 0, 0, 8'h71, 23'h001000, 3'b000, 32'h00000400, 3'b001, 1);
        idle(2);
        drain();

        // Backpressure: two beats fill the pipe, third waits, all emerge in order
        @(negedge clk);
        bus.out_ready = 1'b0;
        send("bp_a", 0, 0, 8'h7F, 23'h000000, 3'b000, 32'h00003C00, 3'b000, 0);
        send("bp_b", 0, 1, 8'h80, 23'h000000, 3'b000, 32'h0000C000, 3'b000, 0);
        @(negedge clk);
        #1;
        check_eq("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        check_eq("bp_out_valid", 64'(bus.out_valid), 64'd1);
        fork
            send("bp_c", 1, 0, 8'h40, 23'h000ABC, 3'b000, 32'h20000ABC, 3'b000, 0);
            begin
                repeat (3) @(negedge clk);
                bus.out_ready = 1'b1;
            end
        join
        idle(2);
        drain();

        // Asynchronous reset with two beats in flight
        @(negedge clk);
        bus.out_ready = 1'b0;
        send("rs_a", 0, 0, 8'h7F, 23'h000000, 3'b000, 32'h00003C00, 3'b000, 0);
        send("rs_b", 0, 0, 8'h80, 23'h000000, 3'b000, 32'h00004000, 3'b000, 0);
        #2;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        check_eq("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("async_rst_out_word", 64'(bus.out_word), 64'd0);
        sb.delete();
        n_base = n_out;
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check_eq("no_stale_beats", 64'(n_out - n_base), 64'd0);
        check_eq("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
